// File: rtl/ltc2333_conv_sequencer_if.sv
// Control and ADC-side signal bundle for ltc2333_conv_sequencer.
// master = register block / ADC side, slave = the sequencer.
interface ltc2333_conv_sequencer_if #(
  parameter int unsigned MAX_CH   = 8,
  parameter int unsigned CFG_BITS = 8
);
  logic                        start;
  logic                        stop;
  logic                        continuous;
  logic [15:0]                 n_conv;
  logic [15:0]                 period;
  logic [3:0]                  n_cfg;
  logic [MAX_CH*CFG_BITS-1:0]  cfg_list;
  logic                        busy;
  logic                        cnv;
  logic                        scki;
  logic                        sdi;
  logic                        frame_start;
  logic                        frame_done;
  logic [3:0]                  cfg_idx;
  logic                        running;
  logic                        done;
  logic                        overrun;

  modport master (
    output start, stop, continuous, n_conv, period, n_cfg, cfg_list, busy,
    input  cnv, scki, sdi, frame_start, frame_done, cfg_idx, running, done, overrun
  );

  modport slave (
    input  start, stop, continuous, n_conv, period, n_cfg, cfg_list, busy,
    output cnv, scki, sdi, frame_start, frame_done, cfg_idx, running, done, overrun
  );
endinterface

// File: rtl/ltc2333_conv_sequencer.sv
// LTC2333 bank sequencer: CNV pulse, conversion wait, SCKI/SDI readout frame carrying the next config word.
// Optional macro LTC2333_BUSY_WAIT_EN: conversion wait ends on BUSY low, TCONV becomes a timeout.
module ltc2333_conv_sequencer #(
  parameter int unsigned CNV_HIGH   = 4,
  parameter int unsigned TCONV      = 64,
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned CFG_BITS   = 8,
  parameter int unsigned MAX_CH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  ltc2333_conv_sequencer_if.slave bus
);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int unsigned DIV_W  = $clog2(2 * SCK_DIV);
  localparam int unsigned LIST_W = MAX_CH * CFG_BITS;

  typedef enum logic [2:0] {IDLE, CNV_HI, CONV_WAIT, SHIFT, GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_pcnt, w_pcnt_nxt, w_pcnt_inc;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [CNT_W-1:0]    r_n_conv, w_n_conv_nxt;
  logic [CNT_W-1:0]    r_period, w_period_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt, w_nbit;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [IDX_W-1:0]    r_next_idx, w_next_idx_nxt;
  logic [IDX_W-1:0]    r_cfg_idx, w_cfg_idx_nxt;
  logic [IDX_W-1:0]    r_ncfg_last, w_ncfg_last_nxt, w_ncfg_last_in;
  logic [LIST_W-1:0]   r_cfg_list, w_cfg_list_nxt;
  logic [CFG_BITS-1:0] w_cfg_word;
  logic                r_cont, w_cont_nxt;
  logic                r_stop_seen, w_stop_seen_nxt;
  logic                r_cnv, w_cnv_nxt;
  logic                r_scki, w_scki_nxt;
  logic                r_sdi, w_sdi_nxt, w_sdi_next;
  logic                r_frame_start, w_frame_start_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic                r_running, w_running_nxt;
  logic                r_done, w_done_nxt;
  logic                r_overrun, w_overrun_nxt;

`ifndef LTC2333_BUSY_WAIT_EN
  logic w_unused_busy;
  assign w_unused_busy = bus.busy;
`endif

  assign w_pcnt_inc = (r_pcnt == {CNT_W{1'b1}}) ? r_pcnt : r_pcnt + CNT_W'(1);
  assign w_nbit     = r_bit + BIT_W'(1);

  // Config word for the next conversion and the SDI bit that follows the current one
  always_comb begin
    w_cfg_word = '0;
    for (int k = 0; k < int'(MAX_CH); k++)
      if (r_next_idx == IDX_W'(k)) w_cfg_word = r_cfg_list[k*CFG_BITS +: CFG_BITS];
    w_sdi_next = 1'b0;
    for (int k = 0; k < int'(CFG_BITS); k++)
      if (w_nbit == BIT_W'(k)) w_sdi_next = w_cfg_word[CFG_BITS-1-k];
  end

  // n_cfg of 0 behaves as 1; anything above MAX_CH is clamped
  always_comb begin
    if (bus.n_cfg == '0)                  w_ncfg_last_in = '0;
    else if (32'(bus.n_cfg) > MAX_CH)     w_ncfg_last_in = IDX_W'(MAX_CH - 1);
    else                                  w_ncfg_last_in = bus.n_cfg - IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pcnt_nxt        = r_pcnt;
    w_count_nxt       = r_count;
    w_n_conv_nxt      = r_n_conv;
    w_period_nxt      = r_period;
    w_bit_nxt         = r_bit;
    w_div_nxt         = r_div;
    w_next_idx_nxt    = r_next_idx;
    w_cfg_idx_nxt     = r_cfg_idx;
    w_ncfg_last_nxt   = r_ncfg_last;
    w_cfg_list_nxt    = r_cfg_list;
    w_cont_nxt        = r_cont;
    w_stop_seen_nxt   = r_stop_seen;
    w_cnv_nxt         = r_cnv;
    w_scki_nxt        = r_scki;
    w_sdi_nxt         = r_sdi;
    w_running_nxt     = r_running;
    w_overrun_nxt     = r_overrun;
    w_frame_start_nxt = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_done_nxt        = 1'b0;

    if (r_state != IDLE && bus.stop) w_stop_seen_nxt = 1'b1;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_overrun_nxt   = 1'b0;
          w_count_nxt     = '0;
          w_stop_seen_nxt = 1'b0;
          w_next_idx_nxt  = '0;
          w_cfg_idx_nxt   = '0;
          w_n_conv_nxt    = bus.n_conv;
          w_period_nxt    = bus.period;
          w_cont_nxt      = bus.continuous;
          w_cfg_list_nxt  = bus.cfg_list;
          w_ncfg_last_nxt = w_ncfg_last_in;
          if (bus.n_conv == '0 && !bus.continuous) begin
            w_done_nxt = 1'b1;
          end else begin
            w_running_nxt = 1'b1;
            w_cnv_nxt     = 1'b1;
            w_pcnt_nxt    = '0;
            w_state_nxt   = CNV_HI;
          end
        end
      end
      CNV_HI: begin
        w_pcnt_nxt = w_pcnt_inc;
        if (r_pcnt >= CNT_W'(CNV_HIGH - 1)) begin
          w_state_nxt = CONV_WAIT;
          w_cnv_nxt   = 1'b0;
          w_sdi_nxt   = w_cfg_word[CFG_BITS-1];
        end
      end
      CONV_WAIT: begin
        w_pcnt_nxt = w_pcnt_inc;
`ifdef LTC2333_BUSY_WAIT_EN
        if (!bus.busy) begin
          w_state_nxt = SHIFT;
        end else if (r_pcnt >= CNT_W'(TCONV - 1)) begin
          w_state_nxt   = SHIFT;
          w_overrun_nxt = 1'b1;
        end
`else
        if (r_pcnt >= CNT_W'(TCONV - 1)) w_state_nxt = SHIFT;
`endif
        if (w_state_nxt == SHIFT) begin
          w_scki_nxt        = 1'b1;
          w_frame_start_nxt = 1'b1;
          w_bit_nxt         = '0;
          w_div_nxt         = '0;
        end
      end
      SHIFT: begin
        w_pcnt_nxt = w_pcnt_inc;
        if (r_div == DIV_W'(2 * SCK_DIV - 1)) begin
          w_div_nxt = '0;
          if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
            w_state_nxt      = GAP;
            w_frame_done_nxt = 1'b1;
            w_count_nxt      = r_count + CNT_W'(1);
            w_cfg_idx_nxt    = r_next_idx;
            w_next_idx_nxt   = (r_next_idx >= r_ncfg_last) ? '0 : r_next_idx + IDX_W'(1);
          end else begin
            w_bit_nxt  = w_nbit;
            w_scki_nxt = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
          // SDI moves on the falling edge so it is stable around the next rise
          if (r_div == DIV_W'(SCK_DIV - 1)) begin
            w_scki_nxt = 1'b0;
            w_sdi_nxt  = w_sdi_next;
          end
        end
      end
      GAP: begin
        w_pcnt_nxt = w_pcnt_inc;
        if (r_stop_seen || bus.stop || (!r_cont && r_count == r_n_conv)) begin
          w_state_nxt   = IDLE;
          w_done_nxt    = 1'b1;
          w_running_nxt = 1'b0;
        end else if (({1'b0, r_pcnt} + 17'd1) >= {1'b0, r_period}) begin
          // Period already used up by the frame: stretch, never truncate
          if (r_pcnt >= r_period) w_overrun_nxt = 1'b1;
          w_state_nxt = CNV_HI;
          w_cnv_nxt   = 1'b1;
          w_pcnt_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt        <= '0;
      r_count       <= '0;
      r_n_conv      <= '0;
      r_period      <= '0;
      r_bit         <= '0;
      r_div         <= '0;
      r_next_idx    <= '0;
      r_cfg_idx     <= '0;
      r_ncfg_last   <= '0;
      r_cfg_list    <= '0;
      r_cont        <= 1'b0;
      r_stop_seen   <= 1'b0;
      r_cnv         <= 1'b0;
      r_scki        <= 1'b0;
      r_sdi         <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_pcnt        <= w_pcnt_nxt;
      r_count       <= w_count_nxt;
      r_n_conv      <= w_n_conv_nxt;
      r_period      <= w_period_nxt;
      r_bit         <= w_bit_nxt;
      r_div         <= w_div_nxt;
      r_next_idx    <= w_next_idx_nxt;
      r_cfg_idx     <= w_cfg_idx_nxt;
      r_ncfg_last   <= w_ncfg_last_nxt;
      r_cfg_list    <= w_cfg_list_nxt;
      r_cont        <= w_cont_nxt;
      r_stop_seen   <= w_stop_seen_nxt;
      r_cnv         <= w_cnv_nxt;
      r_scki        <= w_scki_nxt;
      r_sdi         <= w_sdi_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_running     <= w_running_nxt;
      r_done        <= w_done_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  assign bus.cnv         = r_cnv;
  assign bus.scki        = r_scki;
  assign bus.sdi         = r_sdi;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_done  = r_frame_done;
  assign bus.cfg_idx     = r_cfg_idx;
  assign bus.running     = r_running;
  assign bus.done        = r_done;
  assign bus.overrun     = r_overrun;
endmodule
